match_controller: RTL and testbench

Parametrised successor to the single-match pong sequencer. It is the top-level game FSM. It supports NUM_PADDLES players with per-paddle lives, a timed serve countdown, a toggled pause/resume, auto-repeating paddle-move pulses, and game-over/winner reporting. It sits between the debounced board buttons and the ball/paddle/render blocks, which consume its one-cycle command pulses and level status.

---
 rtl/match_controller.sv | 211 +++++++++++++++++++++
 tb/tb_match_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Top-level pong match FSM: serve countdown, pause toggle, per-paddle lives,
// auto-repeating paddle move pulses and game-over/winner reporting.
module match_controller #(
    parameter int unsigned NUM_PADDLES = 2,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned LIFE_W      = 2,
    parameter int unsigned SERVE_DELAY = 50,
    parameter int unsigned REPEAT_DIV  = 4,
    localparam int unsigned PW = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ready_button,
    input  logic                          pause_button,
    input  logic [NUM_PADDLES-1:0]        left,
    input  logic [NUM_PADDLES-1:0]        right,
    input  logic                          sig_dead,
    input  logic [PW-1:0]                 dead_side,
    output logic                          ready_sig,
    output logic                          start_sig,
    output logic                          play_sig,
    output logic                          pause_sig,
    output logic [NUM_PADDLES-1:0]        left_sig,
    output logic [NUM_PADDLES-1:0]        right_sig,
    output logic [NUM_PADDLES*LIFE_W-1:0] lives,
    output logic                          game_over,
    output logic [PW-1:0]                 winner
);

    localparam int unsigned CW  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam int unsigned RCW = $clog2(REPEAT_DIV) + 1;
    localparam int unsigned LW  = NUM_PADDLES * LIFE_W;

    typedef enum logic [2:0] {
        StIdle,
        StServe,
        StPlay,
        StPause,
        StPoint,
        StOver
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RCW-1:0]          rcnt_q [NUM_PADDLES];
    logic [RCW-1:0]          rcnt_d [NUM_PADDLES];
    logic                    ready_btn_q, pause_btn_q;
    logic                    ready_sig_q, ready_sig_d;
    logic                    start_sig_q, start_sig_d;
    logic                    play_sig_q, play_sig_d;
    logic                    pause_sig_q, pause_sig_d;
    logic                    game_over_q, game_over_d;
    logic [NUM_PADDLES-1:0]  left_sig_q, left_sig_d;
    logic [NUM_PADDLES-1:0]  right_sig_q, right_sig_d;
    logic [LW-1:0]           lives_q, lives_d;
    logic [PW-1:0]           winner_q, winner_d;
    logic                    ready_rise, pause_rise;
    logic [3:0]              alive_cnt;
    logic                    match_done;

    assign ready_rise = ready_button & ~ready_btn_q;
    assign pause_rise = pause_button & ~pause_btn_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lives_d     = lives_q;
        winner_d    = winner_q;
        ready_sig_d = 1'b0;
        start_sig_d = 1'b0;
        alive_cnt   = 4'd0;
        match_done  = 1'b0;

        for (int i = 0; i < int'(NUM_PADDLES); i++) begin
            if (lives_q[i*LIFE_W +: LIFE_W] != '0) begin
                alive_cnt = alive_cnt + 4'd1;
            end
        end

        case (state_q)
            StIdle, StOver: begin
                if (ready_rise) begin
                    ready_sig_d = 1'b1;
                    lives_d     = {NUM_PADDLES{LIFE_W'(LIVES)}};
                    cnt_d       = CW'(SERVE_DELAY - 1);
                    state_d     = StServe;
                end
            end
            StServe: begin
                if (cnt_q == '0) begin
                    start_sig_d = 1'b1;
                    state_d     = StPlay;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPlay: begin
                // A pause edge coinciding with a miss is consumed and dropped.
                if (sig_dead) begin
                    state_d = StPoint;
                    for (int i = 0; i < int'(NUM_PADDLES); i++) begin
                        if (int'(dead_side) == i && lives_q[i*LIFE_W +: LIFE_W] != '0) begin
                            lives_d[i*LIFE_W +: LIFE_W] = lives_q[i*LIFE_W +: LIFE_W] - 1'b1;
                        end
                    end
                end else if (pause_rise) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (pause_rise) begin
                    state_d = StPlay;
                end
            end
            StPoint: begin
                if (NUM_PADDLES > 1) begin
                    match_done = (alive_cnt <= 4'd1);
                end else begin
                    match_done = (alive_cnt == 4'd0);
                end
                if (match_done) begin
                    // Descending scan so the lowest-index survivor wins.
                    winner_d = '0;
                    for (int i = int'(NUM_PADDLES) - 1; i >= 0; i--) begin
                        if (lives_q[i*LIFE_W +: LIFE_W] != '0) begin
                            winner_d = PW'(i);
                        end
                    end
                    state_d = StOver;
                end else begin
                    cnt_d   = CW'(SERVE_DELAY - 1);
                    state_d = StServe;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        play_sig_d  = (state_d == StPlay);
        pause_sig_d = (state_d == StPause);
        game_over_d = (state_d == StOver);
    end

    always_comb begin
        left_sig_d  = '0;
        right_sig_d = '0;
        for (int i = 0; i < int'(NUM_PADDLES); i++) begin
            if (state_q == StPlay && (left[i] ^ right[i]) && !sig_dead) begin
                if (rcnt_q[i] == '0) begin
                    left_sig_d[i]  = left[i];
                    right_sig_d[i] = right[i];
                    rcnt_d[i]      = RCW'(REPEAT_DIV - 1);
                end else begin
                    rcnt_d[i] = rcnt_q[i] - 1'b1;
                end
            end else begin
                rcnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ready_btn_q <= 1'b0;
            pause_btn_q <= 1'b0;
            ready_sig_q <= 1'b0;
            start_sig_q <= 1'b0;
            play_sig_q  <= 1'b0;
            pause_sig_q <= 1'b0;
            game_over_q <= 1'b0;
            left_sig_q  <= '0;
            right_sig_q <= '0;
            lives_q     <= {NUM_PADDLES{LIFE_W'(LIVES)}};
            winner_q    <= '0;
            for (int i = 0; i < int'(NUM_PADDLES); i++) begin
                rcnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_btn_q <= ready_button;
            pause_btn_q <= pause_button;
            ready_sig_q <= ready_sig_d;
            start_sig_q <= start_sig_d;
            play_sig_q  <= play_sig_d;
            pause_sig_q <= pause_sig_d;
            game_over_q <= game_over_d;
            left_sig_q  <= left_sig_d;
            right_sig_q <= right_sig_d;
            lives_q     <= lives_d;
            winner_q    <= winner_d;
            for (int i = 0; i < int'(NUM_PADDLES); i++) begin
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    assign ready_sig = ready_sig_q;
    assign start_sig = start_sig_q;
    assign play_sig  = play_sig_q;
    assign pause_sig = pause_sig_q;
    assign game_over = game_over_q;
    assign left_sig  = left_sig_q;
    assign right_sig = right_sig_q;
    assign lives     = lives_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with default parameters (2 paddles,
// LIVES=3, SERVE_DELAY=50, REPEAT_DIV=4).
module tb_match_controller;

    localparam int SD = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ready_button = 1'b0;
    logic       pause_button = 1'b0;
    logic [1:0] left = 2'b00;
    logic [1:0] right = 2'b00;
    logic       sig_dead = 1'b0;
    logic [0:0] dead_side = 1'b0;
    logic       ready_sig, start_sig, play_sig, pause_sig, game_over;
    logic [1:0] left_sig, right_sig;
    logic [3:0] lives;
    logic [0:0] winner;

    int n_tests = 0;
    int n_fails = 0;

    match_controller dut (
        .clk          (clk),
        .reset        (reset),
        .ready_button (ready_button),
        .pause_button (pause_button),
        .left         (left),
        .right        (right),
        .sig_dead     (sig_dead),
        .dead_side    (dead_side),
        .ready_sig    (ready_sig),
        .start_sig    (start_sig),
        .play_sig     (play_sig),
        .pause_sig    (pause_sig),
        .left_sig     (left_sig),
        .right_sig    (right_sig),
        .lives        (lives),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits out the serve countdown that follows a load at the previous edge,
    // then checks the launch edge.
    task automatic wait_serve(input string tag);
        logic early;
        early = 1'b0;
        for (int i = 0; i < SD - 1; i++) begin
            tick();
            early = early | start_sig | play_sig;
        end
        check_eq({tag, "_no_early_start"}, 32'(early), 32'd0);
        tick();
        check_eq({tag, "_start"}, 32'(start_sig), 32'd1);
        check_eq({tag, "_play"}, 32'(play_sig), 32'd1);
    endtask

    initial begin
        logic [9:0] lpat;
        logic       any;

        // Reset state
        tick();
        tick();
        check_eq("rst_ready_sig", 32'(ready_sig), 32'd0);
        check_eq("rst_start_sig", 32'(start_sig), 32'd0);
        check_eq("rst_play_sig", 32'(play_sig), 32'd0);
        check_eq("rst_pause_sig", 32'(pause_sig), 32'd0);
        check_eq("rst_game_over", 32'(game_over), 32'd0);
        check_eq("rst_moves", 32'({left_sig, right_sig}), 32'd0);
        check_eq("rst_lives", 32'(lives), 32'hF);
        check_eq("rst_winner", 32'(winner), 32'd0);
        reset = 1'b1;
        tick();

        // Serve timing
        ready_button = 1'b1;
        tick();
        check_eq("serve_ready_pulse", 32'(ready_sig), 32'd1);
        check_eq("serve_no_start_k", 32'(start_sig), 32'd0);
        ready_button = 1'b0;
        tick();
        check_eq("serve_ready_one_cycle", 32'(ready_sig), 32'd0);
        any = 1'b0;
        for (int i = 2; i < SD; i++) begin
            tick();
            any = any | start_sig | play_sig;
        end
        check_eq("serve_no_early_start", 32'(any), 32'd0);
        tick();
        check_eq("serve_start_at_k50", 32'(start_sig), 32'd1);
        check_eq("serve_play_at_k50", 32'(play_sig), 32'd1);
        tick();
        check_eq("serve_start_one_cycle", 32'(start_sig), 32'd0);
        check_eq("serve_play_level", 32'(play_sig), 32'd1);

        // Move repeat: left[1] held for 10 cycles
        left = 2'b10;
        lpat = '0;
        any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lpat[i] = left_sig[1];
            any = any | left_sig[0] | (|right_sig);
        end
        check_eq("move_left1_pattern", 32'(lpat), 32'h111);
        check_eq("move_no_other_pulses", 32'(any), 32'd0);
        left = 2'b00;
        tick();
        left = 2'b01;
        right = 2'b01;
        any = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            any = any | (|left_sig) | (|right_sig);
        end
        check_eq("move_both_held_silent", 32'(any), 32'd0);
        left = 2'b00;
        right = 2'b00;
        tick();

        // Pause toggle
        pause_button = 1'b1;
        tick();
        check_eq("pause_sig_on", 32'(pause_sig), 32'd1);
        check_eq("pause_play_off", 32'(play_sig), 32'd0);
        left = 2'b01;
        sig_dead = 1'b1;
        tick();
        check_eq("pause_dead_ignored_lives", 32'(lives), 32'hF);
        check_eq("pause_moves_ignored", 32'(left_sig), 32'd0);
        check_eq("pause_still_paused", 32'(pause_sig), 32'd1);
        sig_dead = 1'b0;
        left = 2'b00;
        tick();
        check_eq("pause_held_one_toggle", 32'(pause_sig), 32'd1);
        pause_button = 1'b0;
        tick();
        pause_button = 1'b1;
        tick();
        check_eq("resume_play", 32'(play_sig), 32'd1);
        check_eq("resume_pause_off", 32'(pause_sig), 32'd0);
        check_eq("resume_no_start", 32'(start_sig), 32'd0);
        pause_button = 1'b0;
        tick();

        // Lives: first miss by paddle 0
        sig_dead = 1'b1;
        dead_side = 1'b0;
        tick();
        check_eq("dead1_play_off", 32'(play_sig), 32'd0);
        check_eq("dead1_lives", 32'(lives), 32'hE);
        sig_dead = 1'b0;
        tick();
        check_eq("point1_no_over", 32'(game_over), 32'd0);
        wait_serve("reserve1");

        // Priority: miss and pause rise on the same edge
        sig_dead = 1'b1;
        pause_button = 1'b1;
        tick();
        check_eq("prio_pause_dropped", 32'(pause_sig), 32'd0);
        check_eq("prio_play_off", 32'(play_sig), 32'd0);
        check_eq("prio_lives", 32'(lives), 32'hD);
        sig_dead = 1'b0;
        pause_button = 1'b0;
        tick();
        check_eq("prio_point_no_pause", 32'(pause_sig), 32'd0);
        wait_serve("prio_reserve");

        // Final miss -> game over, paddle 1 wins
        sig_dead = 1'b1;
        tick();
        check_eq("dead3_lives", 32'(lives), 32'hC);
        sig_dead = 1'b0;
        tick();
        check_eq("over_game_over", 32'(game_over), 32'd1);
        check_eq("over_winner", 32'(winner), 32'd1);
        check_eq("over_play_off", 32'(play_sig), 32'd0);
        tick();
        check_eq("over_holds", 32'(game_over), 32'd1);

        // Restart from OVER
        ready_button = 1'b1;
        tick();
        check_eq("restart_game_over_clr", 32'(game_over), 32'd0);
        check_eq("restart_lives", 32'(lives), 32'hF);
        check_eq("restart_ready_sig", 32'(ready_sig), 32'd1);
        ready_button = 1'b0;

        // Reset at cycle 20 of the countdown
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        check_eq("midserve_rst_play", 32'(play_sig), 32'd0);
        check_eq("midserve_rst_ready", 32'(ready_sig), 32'd0);
        check_eq("midserve_rst_lives", 32'(lives), 32'hF);
        tick();
        tick();
        reset = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 2 * SD; i++) begin
            tick();
            any = any | start_sig | play_sig | pause_sig | game_over;
        end
        check_eq("midserve_no_start_after", 32'(any), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
